// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the two-requester AHB-Lite master arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StLerr
    } state_t;

    typedef struct packed {
        logic        owner;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    // Sizes above a word are rejected along with unaligned addresses.
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = addr_lo[0];
            3'd2:    bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_arb_2way.sv
// Two-way grant logic. AHB_ARB_RR_EN selects round-robin with a last-grant pointer;
// otherwise requester 0 has fixed priority and no state is kept.
module ahb_arb_2way (
`ifdef AHB_ARB_RR_EN
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       accept_i,
`endif
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

`ifdef AHB_ARB_RR_EN
    // ptr_q holds the index of the most recently granted requester.
    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = valid_i;
        if (&valid_i) begin
            grant_o = ptr_q ? 2'b01 : 2'b10;
        end
        ptr_d = accept_i ? grant_o[1] : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign grant_o = {valid_i[1] & ~valid_i[0], valid_i[0]};
`endif

endmodule

// File: rtl/ahb_lite_master_arb.sv
// Arbitrates two command requesters onto one AHB-Lite slave, one single transfer at a time.
// Define AHB_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module ahb_lite_master_arb #(
    parameter logic [3:0]  HPROT_VAL = 4'b0011,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_write,
    input  logic [2:0]        req0_size,
    input  logic [31:0]       req0_wdata,
    output logic              rsp0_valid,
    output logic [31:0]       rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_write,
    input  logic [2:0]        req1_size,
    input  logic [31:0]       req1_wdata,
    output logic              rsp1_valid,
    output logic [31:0]       rsp1_rdata,
    output logic              rsp1_err,

    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [31:0]       HWDATA,
    output logic              HREADY,
    input  logic [31:0]       HRDATA,
    input  logic              HREADYOUT,
    input  logic              HRESP
);

    import ahb_arb_pkg::*;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_owner_q, rsp_owner_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        grant;
    htrans_t           htrans;
    logic              hsel;

`ifdef AHB_ARB_RR_EN
    logic accept;
    assign accept = (state_q == StIdle) && (|grant);
`endif

    ahb_arb_2way u_arb (
`ifdef AHB_ARB_RR_EN
        .clk_i    (HCLK),
        .rst_ni   (HRESETn),
        .accept_i (accept),
`endif
        .valid_i  ({req1_valid, req0_valid}),
        .grant_o  (grant)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        rsp_valid_d = 1'b0;
        rsp_owner_d = rsp_owner_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        htrans      = TransIdle;
        hsel        = 1'b0;
        case (state_q)
            StIdle: begin
                if (|grant) begin
                    cmd_d.owner = grant[1];
                    cmd_d.write = grant[1] ? req1_write : req0_write;
                    cmd_d.size  = grant[1] ? req1_size  : req0_size;
                    cmd_d.wdata = grant[1] ? req1_wdata : req0_wdata;
                    addr_d      = grant[1] ? req1_addr  : req0_addr;
                    state_d     = misaligned(addr_d[1:0], cmd_d.size) ? StLerr : StAddr;
                end
            end
            StAddr: begin
                hsel    = 1'b1;
                htrans  = TransNonseq;
                state_d = StData;
            end
            StData: begin
                // An error's first (HREADYOUT=0) cycle simply extends the data phase.
                if (HREADYOUT) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_owner_d = cmd_q.owner;
                    rsp_rdata_d = cmd_q.write ? 32'h0 : HRDATA;
                    rsp_err_d   = HRESP;
                end
            end
            StLerr: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_owner_d = cmd_q.owner;
                rsp_err_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Ready is forced low while reset is held, even though the FSM already sits in idle.
    assign req0_ready = HRESETn && (state_q == StIdle) && grant[0];
    assign req1_ready = HRESETn && (state_q == StIdle) && grant[1];

    assign rsp0_valid = rsp_valid_q & ~rsp_owner_q;
    assign rsp1_valid = rsp_valid_q &  rsp_owner_q;
    assign rsp0_rdata = rsp_owner_q ? 32'h0 : rsp_rdata_q;
    assign rsp1_rdata = rsp_owner_q ? rsp_rdata_q : 32'h0;
    assign rsp0_err   = rsp_err_q & ~rsp_owner_q;
    assign rsp1_err   = rsp_err_q &  rsp_owner_q;

    assign HSEL   = hsel;
    assign HTRANS = htrans;
    assign HADDR  = addr_q;
    assign HWRITE = cmd_q.write;
    assign HSIZE  = cmd_q.size;
    assign HWDATA = cmd_q.wdata;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_VAL;
    assign HREADY = HREADYOUT;

endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Directed self-checking bench for ahb_lite_master_arb; follows AHB_ARB_RR_EN if defined.
module tb_ahb_lite_master_arb;

    logic        HCLK, HRESETn;
    logic        req0_valid, req0_ready, req0_write;
    logic [15:0] req0_addr;
    logic [2:0]  req0_size;
    logic [31:0] req0_wdata, rsp0_rdata;
    logic        rsp0_valid, rsp0_err;
    logic        req1_valid, req1_ready, req1_write;
    logic [15:0] req1_addr;
    logic [2:0]  req1_size;
    logic [31:0] req1_wdata, rsp1_rdata;
    logic        rsp1_valid, rsp1_err;
    logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA, HRDATA;

    int checks = 0;
    int errors = 0;

    ahb_lite_master_arb #(.HPROT_VAL(4'b0011), .ADDR_W(16)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_write (req0_write),
        .req0_size  (req0_size),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_write (req1_write),
        .req1_size  (req1_size),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic test_reset();
        HRESETn = 1'b0;
        req0_valid = 1'b1; req0_addr = 16'h0; req0_write = 1'b0; req0_size = 3'd0;
        req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_addr = 16'h0; req1_write = 1'b0; req1_size = 3'd0;
        req1_wdata = 32'h0;
        HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        @(negedge HCLK);
        @(negedge HCLK);
        checks++;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b exp 0", req0_ready); end
        checks++;
        if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans got %b exp 00", HTRANS); end
        checks++;
        if (HSEL !== 1'b0) begin errors++; $display("FAIL rst_hsel got %b exp 0", HSEL); end
        checks++;
        if ({HADDR, HWDATA, HSIZE, HWRITE} !== 52'h0) begin
            errors++; $display("FAIL rst_bus got %h %h %h %b exp zeros", HADDR, HWDATA, HSIZE, HWRITE);
        end
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            errors++; $display("FAIL rst_rsp got %b%b exp 00", rsp0_valid, rsp1_valid);
        end
        checks++;
        if ({HBURST, HPROT} !== 7'b000_0011) begin
            errors++; $display("FAIL rst_const got %h %h exp 0 3", HBURST, HPROT);
        end
        req0_valid = 1'b0;
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_write();
        req0_valid = 1'b1; req0_addr = 16'h0010; req0_write = 1'b1; req0_size = 3'd2;
        req0_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL wr_ready got %b%b exp 10", req0_ready, req1_ready);
        end
        @(negedge HCLK); // N+1: address phase
        checks++;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_busy got %b exp 0", req0_ready); end
        req0_valid = 1'b0;
        checks++;
        if ({HSEL, HTRANS} !== 3'b110) begin
            errors++; $display("FAIL wr_nonseq got hsel %b htrans %b exp 1 10", HSEL, HTRANS);
        end
        checks++;
        if ({HADDR, HWRITE, HSIZE, HBURST, HPROT} !== {16'h0010, 1'b1, 3'd2, 3'd0, 4'b0011}) begin
            errors++;
            $display("FAIL wr_ctrl got %h %b %h %h %h exp 0010 1 2 0 3", HADDR, HWRITE, HSIZE,
                     HBURST, HPROT);
        end
        @(negedge HCLK); // N+2: data phase
        checks++;
        if ({HSEL, HTRANS} !== 3'b000) begin
            errors++; $display("FAIL wr_data_idle got hsel %b htrans %b exp 0 00", HSEL, HTRANS);
        end
        checks++;
        if (HWDATA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_hwdata got %h exp deadbeef", HWDATA);
        end
        checks++;
        if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_early got %b exp 0", rsp0_valid); end
        @(negedge HCLK); // N+3: response
        checks++;
        if ({rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL wr_rsp got v%b e%b d%h v1%b exp v1 e0 d0 v1 0", rsp0_valid, rsp0_err,
                     rsp0_rdata, rsp1_valid);
        end
        @(negedge HCLK);
        checks++;
        if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse got %b exp 0", rsp0_valid); end
    endtask

    task automatic test_read_wait();
        req1_valid = 1'b1; req1_addr = 16'h0004; req1_write = 1'b0; req1_size = 3'd2;
        req1_wdata = 32'hA5A5A5A5;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL rd_ready got %b%b exp 01", req0_ready, req1_ready);
        end
        @(negedge HCLK); // N+1
        req1_valid = 1'b0;
        HREADYOUT = 1'b0;
        checks++;
        if ({HTRANS, HADDR, HWRITE} !== {2'b10, 16'h0004, 1'b0}) begin
            errors++; $display("FAIL rd_addr got %b %h %b exp 10 0004 0", HTRANS, HADDR, HWRITE);
        end
        for (int w = 0; w < 2; w++) begin
            @(negedge HCLK); // N+2, N+3: wait states
            checks++;
            if ({HTRANS, HSEL, HADDR, HWDATA, rsp1_valid, HREADY} !==
                {2'b00, 1'b0, 16'h0004, 32'hA5A5A5A5, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rd_wait%0d got %b %b %h %h %b %b exp 00 0 0004 a5a5a5a5 0 0", w,
                         HTRANS, HSEL, HADDR, HWDATA, rsp1_valid, HREADY);
            end
        end
        @(negedge HCLK); // N+4: completion
        HREADYOUT = 1'b1; HRDATA = 32'h12345678;
        #1;
        checks++;
        if (HREADY !== 1'b1) begin errors++; $display("FAIL rd_hready got %b exp 1", HREADY); end
        @(negedge HCLK); // N+5
        HRDATA = 32'h0;
        checks++;
        if ({rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid} !== {1'b1, 1'b0, 32'h12345678, 1'b0}) begin
            errors++;
            $display("FAIL rd_rsp got v%b e%b d%h v0 %b exp v1 e0 d12345678 v0 0", rsp1_valid,
                     rsp1_err, rsp1_rdata, rsp0_valid);
        end
        @(negedge HCLK);
    endtask

    task automatic test_arbitration();
        int exp_w [4];
        int n = 0;
        int prev = -1;
        int w;
        logic prev_rsp;
`ifdef AHB_ARB_RR_EN
        exp_w = '{0, 1, 0, 1};
`else
        exp_w = '{0, 0, 0, 0};
`endif
        req0_valid = 1'b1; req0_addr = 16'h0100; req0_write = 1'b0; req0_size = 3'd2;
        req1_valid = 1'b1; req1_addr = 16'h0200; req1_write = 1'b0; req1_size = 3'd2;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                w = req1_ready ? 1 : 0;
                checks++;
                if (req0_ready && req1_ready) begin
                    errors++; $display("FAIL arb_onehot got 11 exp one-hot");
                end
                checks++;
                if (w != exp_w[n]) begin
                    errors++; $display("FAIL arb_grant%0d got %0d exp %0d", n, w, exp_w[n]);
                end
                if (prev >= 0) begin
                    prev_rsp = (prev == 1) ? rsp1_valid : rsp0_valid;
                    checks++;
                    if (prev_rsp !== 1'b1) begin
                        errors++; $display("FAIL arb_rsp_overlap%0d got %b exp 1", n, prev_rsp);
                    end
                end
                prev = w;
                n++;
            end
            @(negedge HCLK);
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL arb_count got %0d exp 4", n); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge HCLK);
    endtask

    task automatic test_bus_error();
        req0_valid = 1'b1; req0_addr = 16'h0020; req0_write = 1'b0; req0_size = 3'd2;
        @(negedge HCLK); // N+1
        req0_valid = 1'b0;
        HREADYOUT = 1'b0; HRESP = 1'b1;
        req1_valid = 1'b1; req1_addr = 16'h0040; req1_write = 1'b0; req1_size = 3'd2;
        @(negedge HCLK); // N+2: first error cycle
        checks++;
        if ({HTRANS, HSEL, req1_ready} !== 4'b0000) begin
            errors++; $display("FAIL err_cyc1 got %b %b %b exp 00 0 0", HTRANS, HSEL, req1_ready);
        end
        @(negedge HCLK); // N+3: held in data phase
        checks++;
        if ({HTRANS, HSEL, req1_ready, rsp0_valid} !== 5'b00000) begin
            errors++;
            $display("FAIL err_hold got %b %b %b %b exp 00 0 0 0", HTRANS, HSEL, req1_ready,
                     rsp0_valid);
        end
        HREADYOUT = 1'b1;
        @(negedge HCLK); // N+4
        req1_valid = 1'b0; HRESP = 1'b0;
        checks++;
        if ({rsp0_valid, rsp0_err, rsp1_valid, HTRANS} !== 5'b11000) begin
            errors++;
            $display("FAIL err_rsp got v%b e%b v1 %b %b exp 1 1 0 00", rsp0_valid, rsp0_err,
                     rsp1_valid, HTRANS);
        end
        @(negedge HCLK);
    endtask

    task automatic test_misaligned();
        logic [15:0] addrs [3] = '{16'h0003, 16'h0008, 16'h0003};
        logic [2:0]  sizes [3] = '{3'd1, 3'd3, 3'd0};
        logic        bad   [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_addr = addrs[i]; req0_size = sizes[i]; req0_write = 1'b0;
            HRDATA = 32'h00000055;
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin errors++; $display("FAIL mis%0d_ready got %b exp 1", i, req0_ready); end
            @(negedge HCLK); // N+1
            req0_valid = 1'b0;
            checks++;
            if (HTRANS !== (bad[i] ? 2'b00 : 2'b10)) begin
                errors++; $display("FAIL mis%0d_htrans got %b exp %b", i, HTRANS, bad[i] ? 2'b00 : 2'b10);
            end
            @(negedge HCLK); // N+2
            if (bad[i]) begin
                checks++;
                if ({rsp0_valid, rsp0_err, rsp0_rdata, HTRANS} !== {1'b1, 1'b1, 32'h0, 2'b00}) begin
                    errors++;
                    $display("FAIL mis%0d_rsp got v%b e%b d%h %b exp 1 1 0 00", i, rsp0_valid,
                             rsp0_err, rsp0_rdata, HTRANS);
                end
            end else begin
                @(negedge HCLK); // N+3
                checks++;
                if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {1'b1, 1'b0, 32'h55}) begin
                    errors++;
                    $display("FAIL mis%0d_rsp got v%b e%b d%h exp 1 0 55", i, rsp0_valid, rsp0_err,
                             rsp0_rdata);
                end
            end
            HRDATA = 32'h0;
            @(negedge HCLK);
        end
    endtask

    task automatic test_reset_during_data();
        req1_valid = 1'b1; req1_addr = 16'h0030; req1_write = 1'b1; req1_size = 3'd2;
        req1_wdata = 32'hCAFEF00D;
        @(negedge HCLK); // N+1
        req1_valid = 1'b0;
        HREADYOUT = 1'b0;
        @(negedge HCLK); // N+2: data phase
        checks++;
        if (HWDATA !== 32'hCAFEF00D) begin errors++; $display("FAIL rdd_pre got %h exp cafef00d", HWDATA); end
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({HTRANS, HSEL, HWDATA, HADDR} !== 51'h0) begin
            errors++; $display("FAIL rdd_async got %b %b %h %h exp zeros", HTRANS, HSEL, HWDATA, HADDR);
        end
        HREADYOUT = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge HCLK);
            checks++;
            if ({rsp0_valid, rsp1_valid, HTRANS} !== 4'b0000) begin
                errors++;
                $display("FAIL rdd_quiet%0d got %b %b %b exp 0 0 00", c, rsp0_valid, rsp1_valid, HTRANS);
            end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rdd_ptr got %b%b exp 10", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge HCLK);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_arbitration();
        test_bus_error();
        test_misaligned();
        test_reset_during_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
